mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, byte address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width of all data ports.
REQ-003 Parameter MAX_WAIT, 3, debug-port cycles lost before it is forced a grant; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU requests one memory transfer this cycle.
REQ-007 cpu_we  in  1  CPU transfer is a write (1) or a read (0).
REQ-008 cpu_addr  in  ADDR_W  CPU transfer address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU transfer accepted this cycle.
REQ-011 cpu_rvalid  out  1  rd_data holds the CPU read result.
REQ-012 dbg_req  in  1  debug/loader port requests one transfer this cycle.
REQ-013 dbg_we  in  1  debug transfer is a write (1) or a read (0).
REQ-014 dbg_addr  in  ADDR_W  debug transfer address.
REQ-015 dbg_wdata  in  DATA_W  debug write data.
REQ-016 dbg_lock  in  1  debug port requests exclusive ownership across cycles.
REQ-017 dbg_gnt  out  1  debug transfer accepted this cycle.
REQ-018 dbg_rvalid  out  1  rd_data holds the debug read result.
REQ-019 rd_data  out  DATA_W  registered read data, shared; qualified by cpu_rvalid/dbg_rvalid.
REQ-020 mem_addr, mem_wdata  out  ADDR_W, DATA_W  address/data to the shared memory; 0 when idle.
REQ-021 mem_read, mem_write  out  1  memory strobes; memory reads combinationally and writes on clk.
REQ-022 mem_rdata  in  DATA_W  combinational read data from memory.

Function
REQ-023 Grants SHALL be combinational from current state and requests; a transfer occurs in any cycle where req and gnt are both 1; at most one grant per cycle.
REQ-024 Mux: granted port drives mem_addr/mem_wdata; mem_read = granted & ~we, mem_write = granted & we; no grant -> strobes 0, address/data 0.
REQ-025 State ARB: dbg wins if dbg_req & (~cpu_req | wait_cnt == MAX_WAIT); otherwise cpu wins if cpu_req.
REQ-026 wait_cnt: +1 at each cycle end where dbg_req=1 and dbg_gnt=0 (saturates at MAX_WAIT); cleared on dbg grant or dbg_req=0.
REQ-027 ARB -> LOCK when dbg is granted with dbg_lock=1, including starvation-forced grants.
REQ-028 LOCK: dbg_gnt = dbg_req, cpu_gnt = 0; LOCK -> ARB at the cycle end where dbg_lock=0 or dbg_req=0; that cycle still grants dbg if dbg_req=1.
REQ-029 Read latency one cycle: a granted read at cycle N gives the requester's rvalid=1 and rd_data=mem_rdata(N) at cycle N+1, one cycle only; writes never raise rvalid.
REQ-030 rd_data SHALL hold its last value when both rvalid are 0.
REQ-031 Requests SHALL be independent single-cycle transactions: no queuing, and an ungranted requester must hold its req.

Reset
REQ-032 On reset=0, asynchronously: state ARB, wait_cnt 0, cpu_rvalid/dbg_rvalid 0, rd_data 0; an in-flight read result is discarded.
REQ-033 While reset=0, the combinational outputs cpu_gnt, dbg_gnt, mem_read and mem_write SHALL be 0.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state type {ARB, LOCK} and the default ADDR_W, DATA_W and MAX_WAIT constants.
REQ-035 The starvation counter SHALL be the sub-module arb_wait_counter (inputs inc, clr; output at_max), sized for 0..MAX_WAIT.

Verification
REQ-036 cpu read 0x10 alone, mem_rdata=0x00001234 -> cpu_gnt=1, mem_read=1 same cycle; next cycle cpu_rvalid=1, rd_data=0x00001234.
REQ-037 cpu_req and dbg_req held high, MAX_WAIT=3 -> cpu granted cycles 0-2, dbg cycle 3, cpu cycles 4-6, dbg cycle 7.
REQ-038 dbg writes 0x0/0x4/0x8/0xC with dbg_lock=1 while cpu_req=1 -> dbg_gnt 4 consecutive cycles, cpu_gnt=0 throughout, cpu_gnt=1 the cycle after dbg_lock drops.
REQ-039 dbg write 0xC data 0xDEADBEEF alone -> mem_write=1, mem_addr=0xC, mem_wdata=0xDEADBEEF; dbg_rvalid stays 0.
REQ-040 reset pulsed low in LOCK with a read in flight -> rvalid 0, grants 0 during reset; after release cpu_req alone is granted in the first cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
//   arb_state_e : arbiter mode, ARB (priority/starvation) or LOCK (debug owns port)
//   *_DEF       : default address width, data width and debug starvation limit
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_WAIT_DEF = 3;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Counts cycles the debug port has been refused; saturates at MAX_WAIT.
//   clk, reset : clock, async active-low reset
//   inc        : debug requested but was not granted this cycle
//   clr        : debug granted or not requesting (takes priority over inc)
//   at_max     : count has reached MAX_WAIT, debug must win next arbitration
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating counter, cleared whenever debug stops waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_max = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU, debug/loader) in front of one shared memory.
//   clk, reset                    : clock, async active-low reset
//   cpu_req/we/addr/wdata         : CPU transfer request
//   cpu_gnt, cpu_rvalid           : CPU accept (combinational), read result valid
//   dbg_req/we/addr/wdata/lock    : debug transfer request, lock asks for exclusivity
//   dbg_gnt, dbg_rvalid           : debug accept (combinational), read result valid
//   rd_data                       : registered read data shared by both ports
//   mem_addr/wdata/read/write     : memory command, zero when idle
//   mem_rdata                     : combinational memory read data
// CPU has priority, except that debug is forced through after MAX_WAIT lost
// cycles; a granted debug transfer with lock set holds the port until released.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       at_max;
  logic       wait_inc;
  logic       wait_clr;
  logic       cpu_rd;
  logic       dbg_rd;

  // Debug starvation tracking.
  assign wait_inc = dbg_req & ~dbg_gnt;
  assign wait_clr = dbg_gnt | ~dbg_req;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (at_max)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decision and next state; grants are forced low while in reset.
  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    if (reset) begin
      case (state)
        ARB: begin
          if (dbg_req && (!cpu_req || at_max)) begin
            dbg_gnt = 1'b1;
            if (dbg_lock) begin
              state_nxt = LOCK;
            end
          end else begin
            cpu_gnt = cpu_req;
          end
        end
        LOCK: begin
          dbg_gnt = dbg_req;
          if (!dbg_lock || !dbg_req) begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // Memory command mux from the granted port.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_read  = ~dbg_we;
      mem_write = dbg_we;
    end
  end

  assign cpu_rd = cpu_gnt & ~cpu_we;
  assign dbg_rd = dbg_gnt & ~dbg_we;

  // One-cycle read return; rd_data holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      rd_data    <= '0;
    end else begin
      cpu_rvalid <= cpu_rd;
      dbg_rvalid <= dbg_rd;
      if (cpu_rd || dbg_rd) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule
